// File: rtl/seg7_pkg.sv
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared types and helpers for the 7-segment scan driver.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned MAX_DIGITS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    ON   = 2'd2
  } scan_state_t;

  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [4:0] idx);
    return {{(MAX_DIGITS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_slot_timer.sv
// ============================================================================
// Module   : seg7_slot_timer
// Purpose  : Per-slot prescale counter with dead-time-end and slot-end flags.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_slot_timer
  import seg7_pkg::*;
#(
  parameter int unsigned PRESCALE    = 50000,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic dead_end_o,
  output logic slot_end_o
);

  localparam int unsigned          CNT_W     = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0]     DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0]     SLOT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || (cnt_q == SLOT_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign dead_end_o = (cnt_q == DEAD_LAST);
  assign slot_end_o = (cnt_q == SLOT_LAST);

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : N-digit time-multiplexed scan with double buffering, dead time
//            and frame strobe. Define SEG7_SCAN_LZB_EN for leading-zero blanking.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned PRESCALE    = 50000,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          load,
  input  logic [DIGIT_W*N_DIGITS-1:0]   digits_in,
  output logic [DIGIT_W-1:0]            digit_code,
  output logic [N_DIGITS-1:0]           digit_sel,
  output logic                          blank,
  output logic                          frame_done
);

  localparam int unsigned      IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  typedef logic [N_DIGITS-1:0][DIGIT_W-1:0] digits_t;

  scan_state_t          state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  digits_t              active_q, active_d;
  digits_t              shadow_q, shadow_d;
  logic                 pending_q, pending_d;
  logic [DIGIT_W-1:0]   code_q, code_d;
  logic [N_DIGITS-1:0]  sel_q, sel_d;
  logic                 blank_q, blank_d;
  logic                 fdone_q, fdone_d;

  digits_t              load_digits;
  logic                 timer_clear, dead_end, slot_end;
  logic                 frame_end, scan_start;

  assign load_digits = digits_in;
  assign timer_clear = !enable || (state_q == IDLE);
  assign frame_end   = enable && (state_q == ON) && slot_end && (idx_q == LAST_IDX);
  assign scan_start  = enable && (state_q == IDLE);

  seg7_slot_timer #(
    .PRESCALE    (PRESCALE),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (timer_clear),
    .dead_end_o (dead_end),
    .slot_end_o (slot_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      code_q    <= '0;
      sel_q     <= '0;
      blank_q   <= 1'b1;
      fdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      sel_q     <= sel_d;
      blank_q   <= blank_d;
      fdone_q   <= fdone_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = DEAD;
          idx_d   = '0;
        end
        DEAD: begin
          if (dead_end) state_d = ON;
        end
        ON: begin
          if (slot_end) begin
            state_d = DEAD;
            idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Only the frame boundary (or scan start) may touch the displayed digits.
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (frame_end || scan_start) begin
      pending_d = 1'b0;
      if (load) begin
        active_d = load_digits;
        shadow_d = load_digits;
      end else if (pending_q) begin
        active_d = shadow_q;
      end
    end else if (load) begin
      shadow_d  = load_digits;
      pending_d = 1'b1;
    end
  end

`ifdef SEG7_SCAN_LZB_EN
  logic [N_DIGITS-1:0] suppress;

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_lzb
    if (k == 0) begin : g_keep
      assign suppress[k] = 1'b0;
    end else if (k == N_DIGITS - 1) begin : g_msd
      assign suppress[k] = (active_d[k] == '0);
    end else begin : g_mid
      assign suppress[k] = (active_d[k] == '0) && suppress[k+1];
    end
  end
`endif

  // Outputs are decoded from next-state values so they change on the entering edge.
  always_comb begin
    code_d  = '0;
    sel_d   = '0;
    blank_d = 1'b1;
    fdone_d = frame_end;
    if (state_d == ON) begin
      code_d  = active_d[idx_d];
      sel_d   = N_DIGITS'(onehot(5'(idx_d)));
      blank_d = 1'b0;
`ifdef SEG7_SCAN_LZB_EN
      if (suppress[idx_d]) begin
        sel_d   = '0;
        blank_d = 1'b1;
      end
`endif
    end
  end

  assign digit_code = code_q;
  assign digit_sel  = sel_q;
  assign blank      = blank_q;
  assign frame_done = fdone_q;

endmodule

`default_nettype wire
